multi_phase_clock: RTL and testbench
====================================

Name: multi_phase_clock

Overview:
Parametrised successor to the fixed 4-slot instruction/memory clock generator. It divides clk into macro-cycles of 2..2^SLOT_W slots and drives NUM_CH phase outputs, each high over a runtime-programmable slot window. It adds run/halt at macro-cycle boundaries, single-step, and a completed-cycle counter. It sits between the board clock (or PLL) and the CPU stage logic.

Parameters:
SLOT_W, 3, width of the slot index; max 2^SLOT_W slots per macro-cycle
NUM_CH, 2, number of phase outputs (ch 0 = instr, ch 1 = mem in the CPU)
CNT_W, 32, width of the completed macro-cycle counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous reset, active-high
run  input  1  level; 1 = keep issuing macro-cycles
step  input  1  rising edge while halted starts exactly one macro-cycle
last_slot  input  SLOT_W  index of final slot (slots = last_slot+1)
ch_rise  input  NUM_CH x SLOT_W  per-channel first high slot
ch_fall  input  NUM_CH x SLOT_W  per-channel first low slot
ch_out  output  NUM_CH  registered phase outputs
slot  output  SLOT_W  current slot index
cycle_start  output  1  high during slot 0 of every macro-cycle
cycle_end  output  1  high during the final slot
halted  output  1  1 = no macro-cycle in progress
cycle_count  output  CNT_W  number of completed macro-cycles, wraps

Behaviour:
- Reset (reset_n=1, async, immediate even mid-cycle): state HALT, slot=0, ch_out=0, cycle_start=0, cycle_end=0, halted=1, cycle_count=0, step edge detector cleared (step_q=0).
- States: HALT and RUN. All outputs are registered with no combinational path from inputs.
- Step edge: step_rise = step & ~step_q. step_q updates every clk.
- HALT -> RUN on a clk edge with run | step_rise. At that edge:
  - latch last_slot, ch_rise and ch_fall into shadow registers
  - slot<=0, cycle_start<=1, halted<=0, ch_out<=win(0)
  - latency from the sampling edge to the first active output is 1 clk
- RUN, slot != L (L = latched last_slot): slot<=slot+1, ch_out<=win(slot+1), cycle_end<=(slot+1==L), cycle_start<=0.
- RUN, slot == L: cycle_count<=cycle_count+1 (wraps mod 2^CNT_W). Then:
  - if run: start a new macro-cycle exactly as HALT->RUN, including re-latching config. There is no gap slot.
  - else: go to HALT with slot=0, ch_out=0, halted=1, cycle_start=0, cycle_end=0.
- Deasserting run mid-cycle never truncates; the current macro-cycle always completes.
- step is ignored in RUN, including the edge detect; step_q still tracks.
- run and step_rise together in HALT: same as run alone.
- Window function win(s), computed per channel from shadow values r and f:
  - r<f: high iff r<=s<f
  - r>f: high iff s>=r or s<f (wrap-around)
  - r==f: constant 0
  - values above L are used as-is, e.g. f>L with r<=L gives high from r to end of cycle.
- last_slot==0 is treated as 1 (minimum 2 slots).
- Config changes mid-cycle have no effect until the next macro-cycle start.
- Legacy equivalence: last_slot=3, ch0 r=0 f=3, ch1 r=1 f=2. This gives instr high in slots 0-2 and mem high in slot 1, matching the previous generator.

Decomposition:
- Package multi_clock_pkg holds:
  - typedef slot_t (logic [SLOT_W-1:0]) and default SLOT_W
  - state enum {HALT, RUN}
  - legacy constants LEGACY_LAST_SLOT=3, INSTR_RISE=0, INSTR_FALL=3, MEM_RISE=1, MEM_FALL=2
- Sub-module phase_window: combinational win(s) for one channel (inputs s, r, f; output hi), instantiated NUM_CH times via generate.

Test Plan:
- Legacy config, run=1 after reset release: ch0 pattern 1,1,1,0 repeating; ch1 pattern 0,1,0,0; cycle_start in slot 0; cycle_end in slot 3; cycle_count=5 after 20 active clks.
- run 1->0 during slot 1: slots 2 and 3 complete, then halted=1, ch_out=0, cycle_count incremented once; no further slots.
- Halted, step held high 10 clks: exactly one macro-cycle (4 slots) runs, then halt; cycle_count +1 only; a second step rising edge runs one more.
- last_slot=5, ch0 r=4 f=1: ch0 high in slots 4, 5, 0 and low in 1-3; with r=f=2 ch0 stays 0.
- Change ch_rise/last_slot during slot 2: current cycle keeps old window; new values apply from the next slot 0.
- Assert reset_n during slot 2: outputs go 0 and halted=1 immediately (async); with CNT_W=2, count wraps 3->0 after the 4th completed cycle.

Source files
------------

// File: rtl/multi_clock_pkg.sv
// Shared types and constants for the multi-phase clock generator.
package multi_clock_pkg;

    localparam int DEFAULT_SLOT_W = 3;

    typedef logic [DEFAULT_SLOT_W-1:0] slot_t;

    typedef enum logic [0:0] {
        HALT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Settings that reproduce the old fixed 4-slot instruction/memory clock.
    localparam int LEGACY_LAST_SLOT = 3;
    localparam int INSTR_RISE       = 0;
    localparam int INSTR_FALL       = 3;
    localparam int MEM_RISE         = 1;
    localparam int MEM_FALL         = 2;

endpackage

// File: rtl/multi_phase_clock_if.sv
// Control, configuration and status bundle of the multi-phase clock generator.
interface multi_phase_clock_if #(
    parameter int SLOT_W = 3,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);
    logic                           run;
    logic                           step;
    logic [SLOT_W-1:0]              last_slot;
    logic [NUM_CH-1:0][SLOT_W-1:0]  ch_rise;
    logic [NUM_CH-1:0][SLOT_W-1:0]  ch_fall;
    logic [NUM_CH-1:0]              ch_out;
    logic [SLOT_W-1:0]              slot;
    logic                           cycle_start;
    logic                           cycle_end;
    logic                           halted;
    logic [CNT_W-1:0]               cycle_count;

    modport master (
        output run, step, last_slot, ch_rise, ch_fall,
        input  ch_out, slot, cycle_start, cycle_end, halted, cycle_count
    );

    modport slave (
        input  run, step, last_slot, ch_rise, ch_fall,
        output ch_out, slot, cycle_start, cycle_end, halted, cycle_count
    );
endinterface

// File: rtl/phase_window.sv
// Slot window decode for one phase channel: high from rise slot up to (not
// including) fall slot, wrapping through slot 0 when rise is past fall.
module phase_window #(
    parameter int SLOT_W = 3
) (
    input  logic [SLOT_W-1:0] s_i,
    input  logic [SLOT_W-1:0] r_i,
    input  logic [SLOT_W-1:0] f_i,
    output logic              hi_o
);
    // Equal rise/fall disables the channel.
    always_comb begin
        hi_o = 1'b0;
        if (r_i < f_i)
            hi_o = (s_i >= r_i) && (s_i < f_i);
        else if (r_i > f_i)
            hi_o = (s_i >= r_i) || (s_i < f_i);
    end
endmodule

// File: rtl/multi_phase_clock.sv
// Multi-phase clock generator: splits clk into macro-cycles of programmable
// slot count and drives NUM_CH registered phase outputs.
//
// state | meaning
// HALT  | idle, outputs low, waiting for run or a step rising edge
// RUN   | stepping through slots 0..L of the current macro-cycle
module multi_phase_clock
    import multi_clock_pkg::*;
#(
    parameter int SLOT_W = DEFAULT_SLOT_W,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input logic                clk,
    input logic                reset_n,
    multi_phase_clock_if.slave bus
);
    localparam logic [0:0] ST_HALT = HALT;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]                     state_q, state_d;
    logic                           step_q;
    logic [SLOT_W-1:0]              last_q, last_d, slot_q, slot_d;
    logic [NUM_CH-1:0][SLOT_W-1:0]  rise_q, rise_d, fall_q, fall_d;
    logic [NUM_CH-1:0]              ch_q, ch_d, win_hi;
    logic                           cs_q, cs_d, ce_q, ce_d, halted_q, halted_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic                           step_rise, at_last, start;
    logic [SLOT_W-1:0]              last_eff, win_s;
    logic [NUM_CH-1:0][SLOT_W-1:0]  win_r, win_f;

    assign step_rise = bus.step & ~step_q;
    assign at_last   = (slot_q == last_q);
    // In RUN only run matters; step is ignored until the generator halts.
    assign start     = (state_q == ST_HALT) ? (bus.run | step_rise) : (at_last & bus.run);
    // A single-slot macro-cycle is not supported, so 0 is promoted to 1.
    assign last_eff  = (bus.last_slot == '0) ? SLOT_W'(1) : bus.last_slot;

    // On a cycle start the window for slot 0 uses the configuration being latched.
    assign win_s = start ? '0 : slot_q + 1'b1;
    assign win_r = start ? bus.ch_rise : rise_q;
    assign win_f = start ? bus.ch_fall : fall_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_win
        phase_window #(.SLOT_W(SLOT_W)) u_win (
            .s_i  (win_s),
            .r_i  (win_r[g]),
            .f_i  (win_f[g]),
            .hi_o (win_hi[g])
        );
    end

    // Next-state: cycle start, slot advance, or return to halt.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        slot_d   = slot_q;
        ch_d     = ch_q;
        cs_d     = cs_q;
        ce_d     = ce_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (state_q == ST_RUN && at_last)
            cnt_d = cnt_q + 1'b1;
        if (start) begin
            state_d  = ST_RUN;
            last_d   = last_eff;
            rise_d   = bus.ch_rise;
            fall_d   = bus.ch_fall;
            slot_d   = '0;
            ch_d     = win_hi;
            cs_d     = 1'b1;
            ce_d     = 1'b0;
            halted_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (!at_last) begin
                slot_d = win_s;
                ch_d   = win_hi;
                cs_d   = 1'b0;
                ce_d   = (win_s == last_q);
            end else begin
                state_d  = ST_HALT;
                slot_d   = '0;
                ch_d     = '0;
                cs_d     = 1'b0;
                ce_d     = 1'b0;
                halted_d = 1'b1;
            end
        end
    end

    // State and output registers; reset is asynchronous and active-high.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q  <= ST_HALT;
            step_q   <= 1'b0;
            last_q   <= SLOT_W'(1);
            rise_q   <= '0;
            fall_q   <= '0;
            slot_q   <= '0;
            ch_q     <= '0;
            cs_q     <= 1'b0;
            ce_q     <= 1'b0;
            halted_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= bus.step;
            last_q   <= last_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            slot_q   <= slot_d;
            ch_q     <= ch_d;
            cs_q     <= cs_d;
            ce_q     <= ce_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ch_out      = ch_q;
    assign bus.slot        = slot_q;
    assign bus.cycle_start = cs_q;
    assign bus.cycle_end   = ce_q;
    assign bus.halted      = halted_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_multi_phase_clock.sv
// Directed bench for multi_phase_clock (SLOT_W=3, NUM_CH=2, CNT_W=2).
module tb_multi_phase_clock;
    import multi_clock_pkg::*;

    localparam int SW = 3;
    localparam int NC = 2;
    localparam int CW = 2;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;
    int   exp_cnt;

    multi_phase_clock_if #(.SLOT_W(SW), .NUM_CH(NC), .CNT_W(CW)) bus ();

    multi_phase_clock #(.SLOT_W(SW), .NUM_CH(NC), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        logic [31:0] e;
        e = exp_cnt;
        check_eq(tag, 32'(bus.cycle_count), 32'(e[1:0]));
    endtask

    task automatic set_legacy();
        bus.last_slot  = SW'(LEGACY_LAST_SLOT);
        bus.ch_rise[0] = SW'(INSTR_RISE);
        bus.ch_fall[0] = SW'(INSTR_FALL);
        bus.ch_rise[1] = SW'(MEM_RISE);
        bus.ch_fall[1] = SW'(MEM_FALL);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        exp_cnt = 0;
        reset_n = 1'b1;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        set_legacy();
        tick();
        tick();

        // reset state
        check_eq("rst_halted", 32'(bus.halted), 32'd1);
        check_eq("rst_slot", 32'(bus.slot), 32'd0);
        check_eq("rst_ch", 32'(bus.ch_out), 32'd0);
        check_eq("rst_cs", 32'(bus.cycle_start), 32'd0);
        check_eq("rst_ce", 32'(bus.cycle_end), 32'd0);
        check_eq("rst_cnt", 32'(bus.cycle_count), 32'd0);

        // legacy pattern, free running
        reset_n = 1'b0;
        bus.run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int k;
            tick();
            k = i % 4;
            exp_cnt = i / 4;
            check_eq("leg_slot", 32'(bus.slot), 32'(k));
            check_eq("leg_ch", 32'(bus.ch_out), {30'd0, (k == 1), (k < 3)});
            check_eq("leg_cs", 32'(bus.cycle_start), 32'(k == 0));
            check_eq("leg_ce", 32'(bus.cycle_end), 32'(k == 3));
            check_eq("leg_halted", 32'(bus.halted), 32'd0);
            check_cnt("leg_cnt");
        end
        tick();
        exp_cnt = 5;
        check_cnt("leg_cnt5");
        check_eq("leg_wrap_slot", 32'(bus.slot), 32'd0);

        // run dropped in slot 1: cycle completes, then halts
        tick();
        check_eq("stop_s1", 32'(bus.slot), 32'd1);
        bus.run = 1'b0;
        tick();
        check_eq("stop_s2", 32'(bus.slot), 32'd2);
        tick();
        check_eq("stop_s3", 32'(bus.slot), 32'd3);
        check_eq("stop_ce", 32'(bus.cycle_end), 32'd1);
        tick();
        exp_cnt = 6;
        check_eq("stop_halted", 32'(bus.halted), 32'd1);
        check_eq("stop_ch", 32'(bus.ch_out), 32'd0);
        check_cnt("stop_cnt");
        tick();
        tick();
        check_eq("stop_stay", 32'(bus.halted), 32'd1);
        check_cnt("stop_cnt_stay");

        // step held high: exactly one macro-cycle
        bus.step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("step_slot", 32'(bus.slot), 32'(i < 4 ? i : 0));
            check_eq("step_halted", 32'(bus.halted), 32'(i >= 4));
        end
        exp_cnt = 7;
        check_cnt("step_cnt");
        bus.step = 1'b0;
        tick();
        bus.step = 1'b1;
        tick();
        check_eq("step2_run", 32'(bus.halted), 32'd0);
        check_eq("step2_cs", 32'(bus.cycle_start), 32'd1);
        tick();
        tick();
        tick();
        check_eq("step2_s3", 32'(bus.slot), 32'd3);
        tick();
        exp_cnt = 8;
        check_eq("step2_halted", 32'(bus.halted), 32'd1);
        check_cnt("step2_cnt_wrap");
        bus.step = 1'b0;

        // 6 slots, ch0 wrapping window r=4 f=1
        bus.last_slot  = 3'd5;
        bus.ch_rise[0] = 3'd4;
        bus.ch_fall[0] = 3'd1;
        bus.run = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check_eq("wrap_slot", 32'(bus.slot), 32'(i));
            check_eq("wrap_ch", 32'(bus.ch_out), {30'd0, (i == 1), (i >= 4 || i < 1)});
            check_eq("wrap_ce", 32'(bus.cycle_end), 32'(i == 5));
            if (i < 5) tick();
        end
        bus.run = 1'b0;
        tick();
        exp_cnt = 9;
        check_eq("wrap_halted", 32'(bus.halted), 32'd1);
        check_cnt("wrap_cnt");

        // r == f disables ch0
        bus.ch_rise[0] = 3'd2;
        bus.ch_fall[0] = 3'd2;
        bus.run = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check_eq("eq_slot", 32'(bus.slot), 32'(i));
            check_eq("eq_ch", 32'(bus.ch_out), {30'd0, (i == 1), 1'b0});
            if (i < 5) tick();
        end

        // back-to-back restart re-latches config; mid-cycle change deferred
        set_legacy();
        tick();
        exp_cnt = 10;
        check_eq("rel_slot0", 32'(bus.slot), 32'd0);
        check_eq("rel_ch0", 32'(bus.ch_out), 32'd1);
        check_cnt("rel_cnt");
        tick();
        tick();
        check_eq("mid_s2", 32'(bus.slot), 32'd2);
        bus.last_slot  = 3'd4;
        bus.ch_rise[0] = 3'd3;
        bus.ch_fall[0] = 3'd4;
        tick();
        check_eq("mid_s3", 32'(bus.slot), 32'd3);
        check_eq("mid_ch_old", 32'(bus.ch_out), 32'd0);
        check_eq("mid_ce_old", 32'(bus.cycle_end), 32'd1);
        tick();
        exp_cnt = 11;
        check_cnt("mid_cnt");
        for (int i = 0; i < 5; i++) begin
            check_eq("new_slot", 32'(bus.slot), 32'(i));
            check_eq("new_ch", 32'(bus.ch_out), {30'd0, (i == 1), (i == 3)});
            check_eq("new_ce", 32'(bus.cycle_end), 32'(i == 4));
            tick();
        end
        exp_cnt = 12;
        check_cnt("new_cnt");
        tick();
        tick();
        check_eq("pre_rst_slot", 32'(bus.slot), 32'd2);

        // asynchronous reset mid-cycle
        #2;
        reset_n = 1'b1;
        #1;
        check_eq("arst_halted", 32'(bus.halted), 32'd1);
        check_eq("arst_ch", 32'(bus.ch_out), 32'd0);
        check_eq("arst_slot", 32'(bus.slot), 32'd0);
        check_eq("arst_cnt", 32'(bus.cycle_count), 32'd0);
        check_eq("arst_cs", 32'(bus.cycle_start), 32'd0);

        // last_slot == 0 behaves as 2 slots
        tick();
        reset_n = 1'b0;
        set_legacy();
        bus.last_slot = 3'd0;
        bus.run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("min_slot", 32'(bus.slot), 32'(i % 2));
            check_eq("min_ch", 32'(bus.ch_out), {30'd0, (i % 2 == 1), 1'b1});
            check_eq("min_ce", 32'(bus.cycle_end), 32'(i % 2 == 1));
        end
        bus.run = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
